// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment feed controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2,
    DWELL   = 2'd3
  } state_t;

  localparam logic [3:0] TAG_SRC0 = 4'hA;
  localparam logic [3:0] TAG_SRC1 = 4'hB;
  localparam int BCD_DIGITS = 3;

  // Double-dabble correction applied to one BCD nibble before each shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle.
// The first shift happens while the value is loaded, so the result is registered after DATA_W steps.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_W-1:0]         bin,
  output logic                      done,
  output logic [BCD_DIGITS*4-1:0]   bcd
);

  localparam int BW = BCD_DIGITS * 4;
  localparam int CW = $clog2(DATA_W + 1);

  logic [BW-1:0]     bcd_sr;
  logic [DATA_W-1:0] bin_sr;
  logic [CW-1:0]     cnt;
  logic              running;

  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] b, input logic msb);
    logic [BW-1:0] a;
    for (int i = 0; i < BCD_DIGITS; i++) a[i*4 +: 4] = add3(b[i*4 +: 4]);
    return {a[BW-2:0], msb};
  endfunction

  assign done = running && (cnt == CW'(DATA_W));
  assign bcd  = bcd_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_sr  <= '0;
      bin_sr  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      bcd_sr  <= dd_step('0, bin[DATA_W-1]);
      bin_sr  <= bin << 1;
      cnt     <= CW'(1);
      running <= 1'b1;
    end else if (running) begin
      if (done) begin
        running <= 1'b0;
      end else begin
        bcd_sr <= dd_step(bcd_sr, bin_sr[DATA_W-1]);
        bin_sr <= bin_sr << 1;
        cnt    <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seg7_feed_ctrl.sv
// Arbitrates two result sources, converts to BCD and presents a tagged display word.
// Define SEG7_DWELL_EN to hold each displayed value for DWELL_CYCLES before accepting the next.
module seg7_feed_ctrl
  import seg7_pkg::*;
#(
  parameter int DATA_W       = 10,
  parameter int MAX_VAL      = 999,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic [15:0]       bcd,
  output logic              bcd_update,
  output logic              ovf,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  // Handshake: a source's value is taken on the rising edge where its valid and ready are both high.
  // Ready is only ever high in IDLE, and only for the granted source.

  localparam logic [DATA_W-1:0] MAX_W = DATA_W'(MAX_VAL);

  state_t                  state;
  logic                    last_grant;
  logic                    grant;
  logic                    take;
  logic                    sat;
  logic [3:0]              tag;
  logic                    ovf_pending;
  logic [DATA_W-1:0]       sel_data;
  logic [DATA_W-1:0]       eng_data;
  logic                    conv_done;
  logic [BCD_DIGITS*4-1:0] conv_bcd;

`ifdef SEG7_DWELL_EN
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  logic [DW-1:0] dwell_cnt;
`else
  localparam int unused_dwell = DWELL_CYCLES;
`endif

  always_comb begin
    if (in0_valid && in1_valid) grant = ~last_grant;
    else                        grant = in1_valid;
  end

  assign in0_ready = rst_n && (state == IDLE) && in0_valid && !grant;
  assign in1_ready = rst_n && (state == IDLE) && in1_valid && grant;
  assign take      = in0_ready || in1_ready;
  assign sel_data  = grant ? in1_data : in0_data;
  assign sat       = sel_data > MAX_W;
  assign eng_data  = sat ? MAX_W : sel_data;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_conv (
    .clk   (clk1),
    .rst_n (rst_n),
    .start (take),
    .bin   (eng_data),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Display registers load on the edge entering UPDATE so the new word and pulse appear in UPDATE.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state       <= IDLE;
      bcd         <= '0;
      bcd_update  <= 1'b0;
      ovf         <= 1'b0;
      last_grant  <= 1'b1;
      tag         <= '0;
      ovf_pending <= 1'b0;
`ifdef SEG7_DWELL_EN
      dwell_cnt   <= '0;
`endif
    end else begin
      bcd_update <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            tag         <= grant ? TAG_SRC1 : TAG_SRC0;
            ovf_pending <= sat;
            last_grant  <= grant;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            bcd        <= {tag, conv_bcd};
            ovf        <= ovf_pending;
            bcd_update <= 1'b1;
            state      <= UPDATE;
          end
        end
        UPDATE: begin
`ifdef SEG7_DWELL_EN
          dwell_cnt <= '0;
          state     <= DWELL;
`else
          state     <= IDLE;
`endif
        end
`ifdef SEG7_DWELL_EN
        DWELL: begin
          if (dwell_cnt == DW'(DWELL_CYCLES - 1)) state <= IDLE;
          else                                    dwell_cnt <= dwell_cnt + DW'(1);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_feed_ctrl.sv
// Bench for seg7_feed_ctrl: cycle model with expected queue plus directed literal checks.
module tb_seg7_feed_ctrl;

  localparam int DATA_W = 10;
  localparam int DWELL  = 20;
`ifdef SEG7_DWELL_EN
  localparam int EXTRA = DWELL;
`else
  localparam int EXTRA = 0;
`endif
  localparam int GAP = 12 + EXTRA;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              in0_valid = 1'b0;
  logic [DATA_W-1:0] in0_data = '0;
  logic              in0_ready;
  logic              in1_valid = 1'b0;
  logic [DATA_W-1:0] in1_data = '0;
  logic              in1_ready;
  logic [15:0]       bcd;
  logic              bcd_update;
  logic              ovf;
  logic              busy;
  logic [1:0]        fsm_state;

  int total  = 0;
  int passed = 0;

  // clock / reset
  always #5 clk1 = ~clk1;

  seg7_feed_ctrl #(.DATA_W(DATA_W), .MAX_VAL(999), .DWELL_CYCLES(DWELL)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .in0_valid  (in0_valid),
    .in0_data   (in0_data),
    .in0_ready  (in0_ready),
    .in1_valid  (in1_valid),
    .in1_data   (in1_data),
    .in1_ready  (in1_ready),
    .bcd        (bcd),
    .bcd_update (bcd_update),
    .ovf        (ovf),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // scoreboard / reference model
  logic [16:0] exp_q[$];
  int k = 0;
  int idle_from = 0;
  int upd_cycle = -1;
  logic [15:0] m_bcd = '0;
  logic        m_ovf = 1'b0;
  logic        m_last = 1'b1;

  always @(negedge clk1) begin
    logic idle, g, e0, e1, e_upd, s;
    logic [16:0] v;
    int d;
    k++;
    if (!rst_n) begin
      check("ready0_in_reset", {31'd0, in0_ready}, 0);
      check("ready1_in_reset", {31'd0, in1_ready}, 0);
      m_bcd = '0; m_ovf = 1'b0; m_last = 1'b1;
      idle_from = k + 1; upd_cycle = -1;
      exp_q.delete();
    end else begin
      e_upd = (k == upd_cycle);
      if (e_upd && exp_q.size() > 0) begin
        v = exp_q.pop_front();
        m_bcd = v[15:0];
        m_ovf = v[16];
      end
      idle = (k >= idle_from);
      g  = (in0_valid && in1_valid) ? !m_last : in1_valid;
      e0 = idle && in0_valid && !g;
      e1 = idle && in1_valid && g;
      check("model_ready0", {31'd0, in0_ready}, {31'd0, e0});
      check("model_ready1", {31'd0, in1_ready}, {31'd0, e1});
      check("model_busy", {31'd0, busy}, {31'd0, !idle});
      check("model_update", {31'd0, bcd_update}, {31'd0, e_upd});
      check("model_bcd", {16'd0, bcd}, {16'd0, m_bcd});
      check("model_ovf", {31'd0, ovf}, {31'd0, m_ovf});
      if (e0 || e1) begin
        d = g ? int'(in1_data) : int'(in0_data);
        s = (d > 999);
        exp_q.push_back({s, (g ? 4'hB : 4'hA), to_bcd(s ? 999 : d)});
        upd_cycle = k + 11;
        idle_from = k + 12 + EXTRA;
        m_last = g;
      end
    end
  end

  // driver tasks
  task automatic send(input int src, input int data);
    bit got;
    @(posedge clk1); #1;
    if (src == 1) begin in1_valid = 1'b1; in1_data = DATA_W'(data); end
    else          begin in0_valid = 1'b1; in0_data = DATA_W'(data); end
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk1);
      if (src == 1) got = in1_valid && in1_ready;
      else          got = in0_valid && in0_ready;
    end
    check("send_handshake", {31'd0, got}, 1);
    @(posedge clk1); #1;
    if (src == 1) in1_valid = 1'b0; else in0_valid = 1'b0;
  endtask

  task automatic wait_update();
    bit got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk1);
      got = bcd_update;
    end
    check("update_seen", {31'd0, got}, 1);
  endtask

  initial begin
    int n;
    bit got;
    int seen;

    // reset with a pending request
    in0_valid = 1'b1; in0_data = 10'd123;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk1);
      check("reset_ready0", {31'd0, in0_ready}, 0);
    end
    check("reset_bcd", {16'd0, bcd}, 32'h0000);
    check("reset_ovf", {31'd0, ovf}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    @(posedge clk1); #1 rst_n = 1'b1;

    // single conversion of 123 from source 0
    @(negedge clk1);
    check("first_grant_src0", {31'd0, in0_ready}, 1);
    @(posedge clk1); #1 in0_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk1);
      check("single_busy", {31'd0, busy}, 1);
      check("single_pulse", {31'd0, bcd_update}, (i == 11) ? 32'd1 : 32'd0);
      if (i == 11) check("single_bcd", {16'd0, bcd}, 32'hA123);
    end

    // arbitration: both valid continuously, alternates starting with source 1
    @(posedge clk1); #1;
    in0_valid = 1'b1; in0_data = 10'd5;
    in1_valid = 1'b1; in1_data = 10'd987;
    for (int i = 0; i < 6; i++) begin
      wait_update();
      check("arb_seq", {16'd0, bcd}, (i % 2 == 0) ? 32'hB987 : 32'hA005);
    end
    @(posedge clk1); #1;
    in0_valid = 1'b0; in1_valid = 1'b0;

    // saturation and boundary values
    send(1, 1000); wait_update();
    check("ovf_bcd", {16'd0, bcd}, 32'hB999);
    check("ovf_flag", {31'd0, ovf}, 1);
    send(1, 0); wait_update();
    check("zero_bcd", {16'd0, bcd}, 32'hB000);
    check("zero_ovf", {31'd0, ovf}, 0);
    send(0, 999); wait_update();
    check("max_bcd", {16'd0, bcd}, 32'hA999);
    check("max_ovf", {31'd0, ovf}, 0);
    send(0, 1023); wait_update();
    check("top_bcd", {16'd0, bcd}, 32'hA999);
    check("top_ovf", {31'd0, ovf}, 1);

    // back-to-back handshake spacing
    @(posedge clk1); #1 in1_valid = 1'b1; in1_data = 10'd42;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk1);
      got = in1_valid && in1_ready;
    end
    check("gap_first_hs", {31'd0, got}, 1);
    got = 0; n = 0;
    while (!got && n < 200) begin
      @(negedge clk1);
      n++;
      got = in1_valid && in1_ready;
    end
    check("gap_cycles", n, GAP);
    @(posedge clk1); #1 in1_valid = 1'b0;
    wait_update();
    check("gap_bcd", {16'd0, bcd}, 32'hB042);

    // reset in the middle of a conversion
    send(0, 456);
    repeat (4) @(posedge clk1);
    #1 rst_n = 1'b0;
    @(posedge clk1); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      if (bcd_update) seen++;
    end
    check("abort_no_pulse", seen, 0);
    check("abort_bcd", {16'd0, bcd}, 32'h0000);
    send(0, 456); wait_update();
    check("after_abort_bcd", {16'd0, bcd}, 32'hA456);

    repeat (3) @(posedge clk1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
